// File: rtl/pingpong_frame_reader_pkg.sv
// Shared types and defaults for the ping-pong frame-buffer read side.
package pingpong_frame_reader_pkg;

    localparam int unsigned DEF_DATA_W       = 12;
    localparam int unsigned DEF_RD_LATENCY   = 2;
    localparam int unsigned DEF_FRAME_PIXELS = 307200;
    localparam int unsigned DEF_CNT_W        = 19;

    // Encodings match the write-side demux so both ends agree on state values.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } rd_state_t;

    // Per-slot tag that travels alongside an outstanding FIFO read.
    typedef struct packed {
        logic valid;
        logic sel;
        logic zero;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/pingpong_frame_reader_rd_tag_pipe.sv
// Fixed-depth delay line aligning slot tags with read-FIFO data arrival.
module pingpong_frame_reader_rd_tag_pipe
    import pingpong_frame_reader_pkg::*;
#(
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_pipe [RD_LATENCY];

    // Shift tags one stage per clock; reset empties every stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[RD_LATENCY-1];

endmodule

// File: rtl/pingpong_frame_reader.sv
// Reads both frame banks in lockstep and returns (current, previous) pixel pairs,
// ordered by the write-bank parity captured at read-frame start.
module pingpong_frame_reader
    import pingpong_frame_reader_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RD_LATENCY   = DEF_RD_LATENCY,
    parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iFrameCount,
    input  logic              iRdFrameStart,
    input  logic              iRdReq,
    output logic              oRD1,
    output logic              oRD2,
    input  logic              iEmpty1,
    input  logic              iEmpty2,
    input  logic [DATA_W-1:0] iData1,
    input  logic [DATA_W-1:0] iData2,
    output logic [DATA_W-1:0] oCurGray,
    output logic [DATA_W-1:0] oPrevGray,
    output logic              oDVAL,
    output logic              oFrameEnd,
    output logic [1:0]        oErr,
    input  logic              iClrErr
);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_sel_eff;
    logic [CNT_W-1:0]  w_cnt_eff;
    logic              w_issue;
    logic              w_avail;
    logic              w_strobe;
    logic              w_last;
    logic              w_overrun;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_prev;
    logic              r_dval;
    logic              r_fend;
    logic [1:0]        r_err;

    // A frame start in the same cycle as a request makes that request pixel 0
    // with the freshly sampled parity, so the start is folded in combinationally.
    assign w_sel_eff = iRdFrameStart ? iFrameCount : r_sel;
    assign w_cnt_eff = iRdFrameStart ? '0 : r_cnt;
    assign w_last    = (w_cnt_eff == CNT_W'(FRAME_PIXELS - 1));
    assign w_avail   = ~iEmpty1 & ~iEmpty2;

    // FSM state register
    always_ff @(posedge iCLK) begin
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state: final pixel issue wins, otherwise a start (re)enters ACTIVE
    always_comb begin
        w_state_nxt = r_state;
        if (w_issue && w_last)  w_state_nxt = ST_DONE;
        else if (iRdFrameStart) w_state_nxt = ST_ACTIVE;
    end

    // FSM outputs: slot issue, FIFO strobes and overrun detection
    always_comb begin
        w_issue   = iRST_N & iRdReq & ((r_state == ST_ACTIVE) | iRdFrameStart);
        w_strobe  = w_issue & w_avail;
        w_overrun = iRST_N & iRdReq & (r_state == ST_DONE) & ~iRdFrameStart;
    end

    assign oRD1 = w_strobe;
    assign oRD2 = w_strobe;

    // Bank select and pixel counter; select only moves on a frame start
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_sel <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (iRdFrameStart) r_sel <= iFrameCount;
            if (w_issue)            r_cnt <= w_cnt_eff + CNT_W'(1);
            else if (iRdFrameStart) r_cnt <= '0;
        end
    end

    assign w_tag_in = '{valid: w_issue, sel: w_sel_eff, zero: ~w_avail, last: w_last};

    pingpong_frame_reader_rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    // Output mux/registers; pixel values hold between valid slots
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_cur  <= '0;
            r_prev <= '0;
            r_dval <= 1'b0;
            r_fend <= 1'b0;
        end else begin
            r_dval <= w_tag_out.valid;
            r_fend <= w_tag_out.valid & w_tag_out.last;
            if (w_tag_out.valid) begin
                if (w_tag_out.zero) begin
                    r_cur  <= '0;
                    r_prev <= '0;
                end else if (w_tag_out.sel) begin
                    r_cur  <= iData1;
                    r_prev <= iData2;
                end else begin
                    r_cur  <= iData2;
                    r_prev <= iData1;
                end
            end
        end
    end

    // Sticky error flags; a new event in the clear cycle survives the clear
    always_ff @(posedge iCLK) begin
        if (!iRST_N) r_err <= '0;
        else         r_err <= (iClrErr ? 2'b00 : r_err) | {w_overrun, w_issue & ~w_avail};
    end

    assign oCurGray  = r_cur;
    assign oPrevGray = r_prev;
    assign oDVAL     = r_dval;
    assign oFrameEnd = r_fend;
    assign oErr      = r_err;

endmodule

// File: tb/tb_pingpong_frame_reader.sv
// Randomized self-checking bench for pingpong_frame_reader with a small frame.
module tb_pingpong_frame_reader;

    localparam int DW = 12;
    localparam int L  = 2;
    localparam int FP = 8;

    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_DONE = 2;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iFrameCount = 1'b0;
    logic          iRdFrameStart = 1'b0;
    logic          iRdReq = 1'b0;
    logic          oRD1, oRD2;
    logic          iEmpty1 = 1'b0;
    logic          iEmpty2 = 1'b0;
    logic [DW-1:0] iData1 = '0;
    logic [DW-1:0] iData2 = '0;
    logic [DW-1:0] oCurGray, oPrevGray;
    logic          oDVAL, oFrameEnd;
    logic [1:0]    oErr;
    logic          iClrErr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    pingpong_frame_reader #(
        .DATA_W       (DW),
        .RD_LATENCY   (L),
        .FRAME_PIXELS (FP),
        .CNT_W        (4)
    ) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iFrameCount   (iFrameCount),
        .iRdFrameStart (iRdFrameStart),
        .iRdReq        (iRdReq),
        .oRD1          (oRD1),
        .oRD2          (oRD2),
        .iEmpty1       (iEmpty1),
        .iEmpty2       (iEmpty2),
        .iData1        (iData1),
        .iData2        (iData2),
        .oCurGray      (oCurGray),
        .oPrevGray     (oPrevGray),
        .oDVAL         (oDVAL),
        .oFrameEnd     (oFrameEnd),
        .oErr          (oErr),
        .iClrErr       (iClrErr)
    );

    always #5 iCLK = ~iCLK;

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] cur;
        logic [DW-1:0] prev;
        logic          last;
    } slot_t;

    typedef struct packed {
        logic rst_n;
        logic start;
        logic fc;
        logic req;
        logic e1;
        logic e2;
        logic clr;
    } stim_t;

    slot_t         sched[$];
    int            cyc = 0;
    int            m_mode = M_IDLE;
    int            m_cnt = 0;
    logic          m_sel = 1'b0;
    logic [1:0]    m_err = 2'b00;
    logic          exp_dval = 1'b0;
    logic          exp_fe = 1'b0;
    logic [DW-1:0] exp_cur = '0;
    logic [DW-1:0] exp_prev = '0;
    logic [DW-1:0] src1 [L];
    logic [DW-1:0] src2 [L];

    initial begin
        for (int i = 0; i < L; i++) begin
            src1[i] = '0;
            src2[i] = '0;
        end
    end

    always @(posedge iCLK) begin
        logic [1:0] set;
        slot_t      s;
        cyc++;
        for (int i = L - 1; i > 0; i--) begin
            src1[i] = src1[i-1];
            src2[i] = src2[i-1];
        end
        src1[0] = DW'($urandom);
        src2[0] = DW'($urandom);
        if (!iRST_N) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_sel  = 1'b0;
            m_err  = 2'b00;
            sched.delete();
            exp_dval = 1'b0;
            exp_fe   = 1'b0;
            exp_cur  = '0;
            exp_prev = '0;
        end else begin
            exp_dval = 1'b0;
            exp_fe   = 1'b0;
            if (sched.size() > 0 && sched[0].due == cyc) begin
                s = sched.pop_front();
                exp_dval = 1'b1;
                exp_fe   = s.last;
                exp_cur  = s.cur;
                exp_prev = s.prev;
            end
            if (iRdFrameStart) begin
                m_mode = M_ACT;
                m_cnt  = 0;
                m_sel  = iFrameCount;
            end
            set = 2'b00;
            if (iRdReq) begin
                if (m_mode == M_ACT) begin
                    s.due  = cyc + L;
                    s.last = (m_cnt == FP - 1);
                    if (iEmpty1 || iEmpty2) begin
                        set[0] = 1'b1;
                        s.cur  = '0;
                        s.prev = '0;
                    end else begin
                        s.cur  = m_sel ? src1[0] : src2[0];
                        s.prev = m_sel ? src2[0] : src1[0];
                    end
                    sched.push_back(s);
                    m_cnt++;
                    if (m_cnt == FP) m_mode = M_DONE;
                end else if (m_mode == M_DONE) begin
                    set[1] = 1'b1;
                end
            end
            m_err = (iClrErr ? 2'b00 : m_err) | set;
        end
        iData1 <= src1[L-1];
        iData2 <= src2[L-1];
    end

    function automatic logic exp_rd();
        return iRST_N && iRdReq && (iRdFrameStart || m_mode == M_ACT) && !iEmpty1 && !iEmpty2;
    endfunction

    function automatic logic [27:0] exp_vec();
        return {exp_dval, exp_fe, m_err, exp_cur, exp_prev};
    endfunction

    function automatic logic [27:0] obs_vec();
        return {oDVAL, oFrameEnd, oErr, oCurGray, oPrevGray};
    endfunction

    // Apply one cycle of stimulus away from the active edge.
    task automatic step(input stim_t v);
        @(negedge iCLK);
        iRST_N        = v.rst_n;
        iRdFrameStart = v.start;
        iFrameCount   = v.fc;
        iRdReq        = v.req;
        iEmpty1       = v.e1;
        iEmpty2       = v.e2;
        iClrErr       = v.clr;
        #1;
    endtask

    function automatic stim_t mk(input logic rst_n, start, fc, req, e1, e2, clr);
        return '{rst_n: rst_n, start: start, fc: fc, req: req, e1: e1, e2: e2, clr: clr};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t q[$];
        for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL reset_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec() || obs_vec() !== 28'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_parity();
        stim_t q[$];
        for (int p = 1; p >= 0; p--) begin
            q.push_back(mk(1, 1, p[0], 0, 0, 0, 0));
            for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
            for (int i = 0; i < 5; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        end
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL parity_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL parity_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_frame_end();
        stim_t q[$];
        q.push_back(mk(1, 1, 1'($urandom), 0, 0, 0, 0));
        for (int i = 0; i < FP; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL frame_end_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frame_end_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_underflow();
        stim_t q[$];
        q.push_back(mk(1, 1, 1'($urandom), 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) q.push_back(mk(1, 0, 0, 1, 0, (i == 3), 0));
        for (int i = 0; i < 5; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL underflow_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL underflow_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        stim_t q[$];
        q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        for (int i = 0; i < FP - 1; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL restart_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL restart_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL reset_mid_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        stim_t q[$];
        for (int i = 0; i < 400; i++) begin
            q.push_back(mk(($urandom_range(0, 99) != 0),
                           ($urandom_range(0, 19) == 0),
                           1'($urandom),
                           ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 19) == 0)));
        end
        foreach (q[i]) begin
            step(q[i]);
            n_cmp++;
            if ({oRD1, oRD2} !== {2{exp_rd()}}) begin
                n_fail++;
                $display("FAIL random_strobe cyc=%0d got=%b%b want=%b", cyc, oRD1, oRD2, exp_rd());
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_outputs cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_frame_end();
        test_underflow();
        test_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
